// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared hazard-control types and constants for the hazard and forwarding units.
// The register-match helper is the single definition of a "real" RAW dependency.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        MEM_FREEZE = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2,
                                       input logic       uses_rs1,
                                       input logic       uses_rs2);
        return (rd != 5'd0) && ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-register fields into the hazard controller and stage hold/flush controls out.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       ID_Rs1;
    logic [4:0]       ID_Rs2;
    logic             ID_UsesRs1;
    logic             ID_UsesRs2;
    logic             ID_IsBranch;
    logic             ID_BranchTaken;
    logic             EX_RegWrite;
    logic             EX_MemRead;
    logic [4:0]       EX_Rd;
    logic             MEM_MemRead;
    logic [4:0]       MEM_Rd;
    logic             mem_busy;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_stall;
    logic             mem_wb_stall;
    logic             pc_redirect;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, ID_IsBranch, ID_BranchTaken,
               EX_RegWrite, EX_MemRead, EX_Rd, MEM_MemRead, MEM_Rd, mem_busy,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
               mem_wb_stall, pc_redirect, mem_timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, ID_IsBranch, ID_BranchTaken,
               EX_RegWrite, EX_MemRead, EX_Rd, MEM_MemRead, MEM_Rd, mem_busy,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
               mem_wb_stall, pc_redirect, mem_timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller: load-use / branch-operand stalls, memory freeze, branch redirect
// (deferred across a freeze), memory-busy watchdog and stall/flush performance counters.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_hazard_controller_if.slave bus
);

    localparam int unsigned      WD_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(MEM_TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    hz_state_e        r_state;
    logic             r_pending;
    logic             r_timeout_err;
    logic [WD_W-1:0]  r_wd_cnt;

    logic             w_match_ex;
    logic             w_match_mem;
    logic             w_hazard;
    logic             w_frozen;
    logic             w_dstall;
    logic             w_redirect;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    assign w_match_ex  = reg_match(bus.EX_Rd,  bus.ID_Rs1, bus.ID_Rs2, bus.ID_UsesRs1, bus.ID_UsesRs2);
    assign w_match_mem = reg_match(bus.MEM_Rd, bus.ID_Rs1, bus.ID_Rs2, bus.ID_UsesRs1, bus.ID_UsesRs2);

    // Branch-on-load stalls twice: once while the load is in EX, once while it is in MEM.
    assign w_hazard = (bus.EX_MemRead && w_match_ex)
                    || (bus.ID_IsBranch && (bus.EX_RegWrite || bus.EX_MemRead) && w_match_ex)
                    || (bus.ID_IsBranch && bus.MEM_MemRead && w_match_mem);

    // The cycle on which mem_busy drops is already unfrozen, so freeze tracks mem_busy directly.
    assign w_frozen   = rst_n && bus.mem_busy;
    assign w_dstall   = rst_n && !bus.mem_busy && w_hazard;
    assign w_redirect = rst_n && !bus.mem_busy && !w_hazard && (r_pending || bus.ID_BranchTaken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pending     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wd_cnt      <= '0;
        end else begin
            case (r_state)
                RUN:        if (bus.mem_busy)  r_state <= MEM_FREEZE;
                MEM_FREEZE: if (!bus.mem_busy) r_state <= RUN;
                default:                       r_state <= RUN;
            endcase

            if (w_redirect) begin
                r_pending <= 1'b0;
            end else if (bus.mem_busy && bus.ID_BranchTaken && !w_hazard) begin
                r_pending <= 1'b1;
            end

            if (bus.mem_busy) begin
                if (r_wd_cnt != WD_MAX) begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                end
                if (r_wd_cnt == WD_LAST) begin
                    r_timeout_err <= 1'b1;
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_frozen | w_dstall),
        .cnt   (w_stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_redirect),
        .cnt   (w_flush_cnt)
    );

    assign bus.pc_stall        = w_frozen | w_dstall;
    assign bus.if_id_stall     = w_frozen | w_dstall;
    assign bus.id_ex_bubble    = w_dstall;
    assign bus.ex_mem_stall    = w_frozen;
    assign bus.mem_wb_stall    = w_frozen;
    assign bus.pc_redirect     = w_redirect;
    assign bus.if_id_flush     = w_redirect;
    assign bus.mem_timeout_err = r_timeout_err;
    assign bus.stall_cnt       = w_stall_cnt;
    assign bus.flush_cnt       = w_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: vector table, corner-case sequences and random
// stimulus compared against a rule-level reference model.
module tb_pipeline_hazard_controller;

    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(32)) bus ();

    pipeline_hazard_controller #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic       sc_inc;
    logic [2:0] sc_cnt;
    hazard_sat_counter #(.CNT_W(3)) u_sc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sc_inc),
        .cnt   (sc_cnt)
    );

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, isbr, taken, exrw, exmr;
        logic [4:0] exrd;
        logic       memmr;
        logic [4:0] memrd;
        logic       busy;
    } in_t;

    typedef struct {
        in_t  in;
        logic stall, bubble, redir;
    } vec_t;

    int total = 0;
    int bad   = 0;

    in_t cur;
    bit     m_pend, m_err;
    int     m_run;
    longint m_scnt, m_fcnt;

    function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input bit isbr, input bit taken, input bit exrw, input bit exmr,
                               input int exrd, input bit memmr, input int memrd, input bit busy);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
        v.isbr = isbr; v.taken = taken; v.exrw = exrw; v.exmr = exmr;
        v.exrd = 5'(exrd); v.memmr = memmr; v.memrd = 5'(memrd); v.busy = busy;
        return v;
    endfunction

    task automatic apply(input in_t v);
        bus.ID_Rs1 = v.rs1;          bus.ID_Rs2 = v.rs2;
        bus.ID_UsesRs1 = v.u1;       bus.ID_UsesRs2 = v.u2;
        bus.ID_IsBranch = v.isbr;    bus.ID_BranchTaken = v.taken;
        bus.EX_RegWrite = v.exrw;    bus.EX_MemRead = v.exmr;
        bus.EX_Rd = v.exrd;          bus.MEM_MemRead = v.memmr;
        bus.MEM_Rd = v.memrd;        bus.mem_busy = v.busy;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: does instruction in ID read register r (x0 never counts)?
    function automatic bit reads(input in_t v, input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (v.u1 && v.rs1 == r) || (v.u2 && v.rs2 == r);
    endfunction

    function automatic void model(input in_t v, input bit pend,
                                  output bit fz, output bit ds, output bit rd);
        bit load_use, br_ex, br_mem, hz;
        load_use = v.exmr && reads(v, v.exrd);
        br_ex    = v.isbr && (v.exrw || v.exmr) && reads(v, v.exrd);
        br_mem   = v.isbr && v.memmr && reads(v, v.memrd);
        hz = load_use || br_ex || br_mem;
        fz = v.busy;
        ds = !fz && hz;
        rd = !fz && !hz && (pend || v.taken);
    endfunction

    task automatic drive_and_check(input in_t v, input string tag);
        bit fz, ds, rd;
        @(negedge clk);
        cur = v;
        apply(v);
        #1;
        model(v, m_pend, fz, ds, rd);
        check({tag, ".pc_stall"},     bus.pc_stall,        fz | ds);
        check({tag, ".if_id_stall"},  bus.if_id_stall,     fz | ds);
        check({tag, ".id_ex_bubble"}, bus.id_ex_bubble,    ds);
        check({tag, ".ex_mem_stall"}, bus.ex_mem_stall,    fz);
        check({tag, ".mem_wb_stall"}, bus.mem_wb_stall,    fz);
        check({tag, ".pc_redirect"},  bus.pc_redirect,     rd);
        check({tag, ".if_id_flush"},  bus.if_id_flush,     rd);
        check({tag, ".timeout_err"},  bus.mem_timeout_err, m_err);
        check({tag, ".stall_cnt"},    bus.stall_cnt,       m_scnt);
        check({tag, ".flush_cnt"},    bus.flush_cnt,       m_fcnt);
    endtask

    task automatic tick();
        bit fz, ds, rd;
        model(cur, m_pend, fz, ds, rd);
        @(posedge clk);
        if (rd) m_pend = 1'b0;
        else if (cur.busy && cur.taken && !ds && !(cur.exmr && reads(cur, cur.exrd))
                 && !(cur.isbr && (((cur.exrw || cur.exmr) && reads(cur, cur.exrd))
                                   || (cur.memmr && reads(cur, cur.memrd)))))
            m_pend = 1'b1;
        if (cur.busy) begin
            m_run++;
            if (m_run == TIMEOUT) m_err = 1'b1;
        end else begin
            m_run = 0;
        end
        if ((fz || ds) && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        if (rd && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
    endtask

    task automatic step(input in_t v, input string tag);
        drive_and_check(v, tag);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pc_stall"},     bus.pc_stall,        0);
        check({tag, ".if_id_stall"},  bus.if_id_stall,     0);
        check({tag, ".if_id_flush"},  bus.if_id_flush,     0);
        check({tag, ".id_ex_bubble"}, bus.id_ex_bubble,    0);
        check({tag, ".ex_mem_stall"}, bus.ex_mem_stall,    0);
        check({tag, ".mem_wb_stall"}, bus.mem_wb_stall,    0);
        check({tag, ".pc_redirect"},  bus.pc_redirect,     0);
        check({tag, ".timeout_err"},  bus.mem_timeout_err, 0);
        check({tag, ".stall_cnt"},    bus.stall_cnt,       0);
        check({tag, ".flush_cnt"},    bus.flush_cnt,       0);
    endtask

    vec_t   tbl[10];
    in_t    zero, v;
    longint snap;

    initial begin
        //            rs1 rs2 u1 u2 br tk rw mr exrd mmr mrd busy      stall bub redir
        tbl[0] = '{mk(5, 0, 1, 0, 0, 0, 1, 1, 5, 0, 0, 0), 1'b1, 1'b1, 1'b0};
        tbl[1] = '{mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0};
        tbl[2] = '{mk(5, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0), 1'b0, 1'b0, 1'b0};
        tbl[3] = '{mk(1, 7, 0, 1, 0, 0, 1, 1, 7, 0, 0, 0), 1'b1, 1'b1, 1'b0};
        tbl[4] = '{mk(3, 0, 1, 0, 1, 1, 1, 0, 3, 0, 0, 0), 1'b1, 1'b1, 1'b0};
        tbl[5] = '{mk(3, 0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0), 1'b0, 1'b0, 1'b0};
        tbl[6] = '{mk(2, 9, 0, 1, 1, 1, 0, 0, 0, 1, 9, 0), 1'b1, 1'b1, 1'b0};
        tbl[7] = '{mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 0), 1'b0, 1'b0, 1'b0};
        tbl[8] = '{mk(4, 6, 1, 1, 1, 1, 1, 0, 8, 1, 2, 0), 1'b0, 1'b0, 1'b1};
        tbl[9] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1};

        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_pend = 0; m_err = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
        sc_inc = 1'b0;

        // Reset holds every output low even with a busy memory and a load-use pattern present.
        cur = tbl[0].in;
        cur.busy = 1'b1;
        apply(cur);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        cur = zero;
        apply(cur);
        rst_n = 1'b1;

        @(negedge clk) sc_inc = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) check("satcnt.5", sc_cnt, 5);
        repeat (6) @(posedge clk);
        @(negedge clk) check("satcnt.sat", sc_cnt, 7);
        sc_inc = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive_and_check(tbl[i].in, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_stall", i),  bus.pc_stall,     tbl[i].stall);
            check($sformatf("vec%0d.tbl_bubble", i), bus.id_ex_bubble, tbl[i].bubble);
            check($sformatf("vec%0d.tbl_redir", i),  bus.pc_redirect,  tbl[i].redir);
            tick();
        end
        step(zero, "idle0");

        // x0 destination never stalls and leaves the stall counter untouched.
        snap = m_scnt;
        step(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0), "x0dep");
        drive_and_check(zero, "x0dep_after");
        check("x0dep.stall_cnt_same", bus.stall_cnt, snap);
        tick();

        // beq on a load: two stall cycles, then a single redirect.
        drive_and_check(mk(5, 0, 1, 1, 1, 1, 1, 1, 5, 0, 0, 0), "brload.c1");
        check("brload.c1.stall", bus.pc_stall, 1);
        tick();
        drive_and_check(mk(5, 0, 1, 1, 1, 1, 0, 0, 0, 1, 5, 0), "brload.c2");
        check("brload.c2.stall", bus.pc_stall, 1);
        check("brload.c2.redir", bus.pc_redirect, 0);
        tick();
        drive_and_check(mk(5, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), "brload.c3");
        check("brload.c3.redir", bus.pc_redirect, 1);
        tick();
        step(zero, "brload.c4");

        // Taken branch held through a 3-cycle freeze fires exactly once afterwards.
        for (int i = 0; i < 3; i++) begin
            drive_and_check(mk(1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1), $sformatf("frz.c%0d", i + 1));
            check($sformatf("frz.c%0d.redir", i + 1), bus.pc_redirect, 0);
            tick();
        end
        drive_and_check(mk(1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), "frz.c4");
        check("frz.c4.redir", bus.pc_redirect, 1);
        tick();
        drive_and_check(zero, "frz.c5");
        check("frz.c5.redir", bus.pc_redirect, 0);
        tick();

        // Branch resolved mid-freeze only: the deferred redirect fires with taken already low.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "pend.c1");
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), "pend.c2");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "pend.c3");
        drive_and_check(zero, "pend.c4");
        check("pend.c4.redir", bus.pc_redirect, 1);
        tick();
        drive_and_check(zero, "pend.c5");
        check("pend.c5.redir", bus.pc_redirect, 0);
        tick();

        for (int n = 0; n < 400; n++) begin
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom);
            v.u2    = 1'($urandom);
            v.isbr  = 1'($urandom);
            v.taken = ($urandom_range(0, 2) == 0);
            v.exrw  = 1'($urandom);
            v.exmr  = 1'($urandom);
            v.exrd  = 5'($urandom_range(0, 3));
            v.memmr = 1'($urandom);
            v.memrd = 5'($urandom_range(0, 3));
            v.busy  = ($urandom_range(0, 5) == 0);
            step(v, $sformatf("rnd%0d", n));
        end
        step(zero, "idle1");

        // Watchdog: flag appears only after the 64th consecutive busy cycle, then sticks.
        for (int i = 1; i <= TIMEOUT; i++) begin
            drive_and_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("wd%0d", i));
            if (i == TIMEOUT) check("wd.before64", bus.mem_timeout_err, 0);
            tick();
        end
        drive_and_check(zero, "wd.after");
        check("wd.set", bus.mem_timeout_err, 1);
        tick();
        step(zero, "wd.after2");
        drive_and_check(zero, "wd.after3");
        check("wd.sticky", bus.mem_timeout_err, 1);
        tick();

        // Async reset during a freeze with a redirect pending discards the redirect.
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), "rstfrz.c1");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rstfrz.async");
        m_pend = 0; m_err = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
        @(negedge clk);
        cur = zero;
        apply(cur);
        rst_n = 1'b1;
        drive_and_check(zero, "rstfrz.rel1");
        check("rstfrz.rel1.redir", bus.pc_redirect, 0);
        tick();
        drive_and_check(zero, "rstfrz.rel2");
        check("rstfrz.rel2.redir", bus.pc_redirect, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
